// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory request/response path.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_LEN_B = 2'd0,
        DMEM_LEN_H = 2'd1,
        DMEM_LEN_W = 2'd2
    } dmem_len_e;

    localparam logic DMEM_MTYPE_RD = 1'b0;
    localparam logic DMEM_MTYPE_WR = 1'b1;

    typedef struct packed {
        logic       vld;
        logic       mtype;
        logic [1:0] len;
    } dmem_req_ctrl_t;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic        mtype;
        logic [31:0] rdata;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core memory stage and a data-memory responder.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    dmem_req_ctrl_t req_ctrl;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           req_rdy;
    logic           resp_vld;
    logic [31:0]    resp_rdata;
    logic           resp_err;
    logic           resp_mtype;
    logic           resp_rdy;

    modport master (
        output req_ctrl, req_addr, req_wdata, resp_rdy,
        input  req_rdy, resp_vld, resp_rdata, resp_err, resp_mtype
    );

    modport slave (
        input  req_ctrl, req_addr, req_wdata, resp_rdy,
        output req_rdy, resp_vld, resp_rdata, resp_err, resp_mtype
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for sub-word accesses: write enables/lanes, read shift/mask, alignment errors.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  len,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata,
    output logic        align_err
);

    logic [31:0] shifted;

    always_comb begin
        be        = '0;
        wlanes    = wdata;
        rdata     = '0;
        align_err = 1'b0;
        shifted   = rword >> {addr_lo, 3'b000};
        case (len)
            DMEM_LEN_B: begin
                be     = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
                rdata  = {24'b0, shifted[7:0]};
            end
            DMEM_LEN_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes    = {2{wdata[15:0]}};
                rdata     = {16'b0, shifted[15:0]};
                align_err = addr_lo[0];
            end
            DMEM_LEN_W: begin
                be        = 4'b1111;
                rdata     = shifted;
                align_err = |addr_lo;
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised SRAM with byte/half/word access and fixed wait-state latency.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit          BYPASS = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_rsp_state_e;

    dmem_rsp_state_e state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            req_rdy, accept, enter_resp;

    logic [31:0]     addr_q, wdata_q;
    logic            mtype_q;
    logic [1:0]      len_q;

    logic [31:0]     act_addr, act_wdata, offset;
    logic            act_mtype;
    logic [1:0]      act_len;
    logic [AW-1:0]   idx;
    logic            range_err, align_err, err;
    logic [3:0]      be;
    logic [31:0]     wlanes, rdata_al;

    logic [31:0]     mem [DEPTH];
    dmem_resp_t      resp_q;

    always_comb begin
        req_rdy    = (state == IDLE) || (state == RESP && bus.resp_rdy);
        accept     = bus.req_ctrl.vld && req_rdy;
        state_n    = state;
        cnt_n      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (BYPASS) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RESP: begin
                if (bus.resp_rdy) begin
                    state_n = IDLE;
                    if (accept) begin
                        if (BYPASS) begin
                            state_n    = RESP;
                            enter_resp = 1'b1;
                        end else begin
                            state_n = WAIT;
                            cnt_n   = CW'(LATENCY - 1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // With single-cycle latency the access happens on the accept edge, so the
    // live bus request is used instead of the not-yet-loaded request registers.
    always_comb begin
        if (BYPASS && accept) begin
            act_addr  = bus.req_addr;
            act_wdata = bus.req_wdata;
            act_mtype = bus.req_ctrl.mtype;
            act_len   = bus.req_ctrl.len;
        end else begin
            act_addr  = addr_q;
            act_wdata = wdata_q;
            act_mtype = mtype_q;
            act_len   = len_q;
        end
        offset    = act_addr - BASE_ADDR;
        range_err = (offset >> 2) >= 32'(DEPTH);
        idx       = offset[AW+1:2];
        err       = range_err || align_err;
    end

    dmem_lane_align u_lane_align (
        .addr_lo   (act_addr[1:0]),
        .len       (act_len),
        .wdata     (act_wdata),
        .rword     (mem[idx]),
        .be        (be),
        .wlanes    (wlanes),
        .rdata     (rdata_al),
        .align_err (align_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            resp_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mtype_q <= 1'b0;
            len_q   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            resp_q.vld <= (state_n == RESP);
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                mtype_q <= bus.req_ctrl.mtype;
                len_q   <= bus.req_ctrl.len;
            end
            if (enter_resp) begin
                resp_q.err   <= err;
                resp_q.mtype <= act_mtype;
                resp_q.rdata <= (err || act_mtype == DMEM_MTYPE_WR) ? '0 : rdata_al;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && !err && act_mtype == DMEM_MTYPE_WR) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    assign bus.req_rdy    = req_rdy;
    assign bus.resp_vld   = resp_q.vld;
    assign bus.resp_rdata = resp_q.rdata;
    assign bus.resp_err   = resp_q.err;
    assign bus.resp_mtype = resp_q.mtype;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and model-checked traffic against a LATENCY=1 and a LATENCY=4 responder.
module tb_dmem_responder;

    localparam logic       RD = 1'b0;
    localparam logic       WR = 1'b1;
    localparam logic [1:0] LB = 2'd0;
    localparam logic [1:0] LH = 2'd1;
    localparam logic [1:0] LW = 2'd2;
    localparam logic [1:0] LR = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d  [2];
    logic [3:0]  ctrl_d [2];
    logic [31:0] addr_d [2];
    logic [31:0] wd_d   [2];
    logic        rdy_d  [2];
    logic        rrdy_o [2];
    logic        vld_o  [2];
    logic [31:0] rd_o   [2];
    logic        err_o  [2];
    logic        mt_o   [2];

    int n_checks = 0;
    int n_fail   = 0;
    int lat_exp [2] = '{1, 4};

    logic [7:0] ref_b [256];

    dmem_responder_if bus1 ();
    dmem_responder_if bus4 ();

    assign bus1.req_ctrl  = ctrl_d[0];
    assign bus1.req_addr  = addr_d[0];
    assign bus1.req_wdata = wd_d[0];
    assign bus1.resp_rdy  = rdy_d[0];
    assign rrdy_o[0] = bus1.req_rdy;
    assign vld_o[0]  = bus1.resp_vld;
    assign rd_o[0]   = bus1.resp_rdata;
    assign err_o[0]  = bus1.resp_err;
    assign mt_o[0]   = bus1.resp_mtype;

    assign bus4.req_ctrl  = ctrl_d[1];
    assign bus4.req_addr  = addr_d[1];
    assign bus4.req_wdata = wd_d[1];
    assign bus4.resp_rdy  = rdy_d[1];
    assign rrdy_o[1] = bus4.req_rdy;
    assign vld_o[1]  = bus4.resp_vld;
    assign rd_o[1]   = bus4.resp_rdata;
    assign err_o[1]  = bus4.resp_err;
    assign mt_o[1]   = bus4.resp_mtype;

    dmem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_d[0]),
        .bus   (bus1)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(4), .BASE_ADDR(32'h0000_0000)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_d[1]),
        .bus   (bus4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; response held for `stall` cycles with resp_rdy low before release.
    task automatic op(input int k, input logic mt, input logic [1:0] len, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int stall, input string tag);
        int n;
        logic [31:0] rd0;
        bit stable;
        @(negedge clk);
        check_eq({tag, "/idle"}, 32'(vld_o[k]), 32'd0);
        ctrl_d[k] = {1'b1, mt, len};
        addr_d[k] = addr;
        wd_d[k]   = wd;
        rdy_d[k]  = (stall == 0);
        #1;
        check_eq({tag, "/req_rdy"}, 32'(rrdy_o[k]), 32'd1);
        @(posedge clk);
        #1;
        ctrl_d[k] = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_o[k] && n < 20);
        check_eq({tag, "/lat"}, 32'(n), 32'(lat_exp[k]));
        check_eq({tag, "/rdata"}, rd_o[k], exp_rd);
        check_eq({tag, "/err"}, 32'(err_o[k]), 32'(exp_err));
        check_eq({tag, "/mtype"}, 32'(mt_o[k]), 32'(mt));
        rd0 = rd_o[k];
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (!vld_o[k] || rd_o[k] !== rd0 || rrdy_o[k] !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        if (stall > 0) check_eq({tag, "/stall_hold"}, 32'(stable), 32'd1);
        rdy_d[k] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit stable;
        logic [31:0] a, wd, exp;
        logic [1:0] len;
        logic mt, e;
        logic [7:0] ia;

        for (int k = 0; k < 2; k++) begin
            rst_d[k] = 1'b0; ctrl_d[k] = '0; addr_d[k] = '0; wd_d[k] = '0; rdy_d[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_d[0] = 1'b1;
        rst_d[1] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst/req_rdy", 32'(rrdy_o[k]), 32'd1);
            check_eq("rst/vld", 32'(vld_o[k]), 32'd0);
            check_eq("rst/rdata", rd_o[k], 32'd0);
            check_eq("rst/err", 32'(err_o[k]), 32'd0);
            check_eq("rst/mtype", 32'(mt_o[k]), 32'd0);
        end

        // Basic word write/read, then sub-word merge
        op(0, WR, LW, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, "sw10");
        op(0, RD, LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "lw10");
        op(0, WR, LB, 32'h13, 32'h0000_00A5, 32'h0, 1'b0, 0, "sb13");
        op(0, WR, LH, 32'h10, 32'h0000_1234, 32'h0, 1'b0, 0, "sh10");
        op(0, RD, LW, 32'h10, 32'h0, 32'hA5AD_1234, 1'b0, 0, "lw10b");
        op(0, RD, LB, 32'h13, 32'h0, 32'h0000_00A5, 1'b0, 0, "lb13");
        op(0, RD, LH, 32'h12, 32'h0, 32'h0000_A5AD, 1'b0, 0, "lh12");
        op(0, RD, LB, 32'h11, 32'h0, 32'h0000_0012, 1'b0, 0, "lb11");

        // Error cases; 0x20 must survive the rejected writes
        op(0, WR, LW, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 0, "sw20");
        op(0, RD, LH, 32'h11, 32'h0, 32'h0, 1'b1, 0, "err_lh11");
        op(0, WR, LW, 32'h22, 32'h5555_5555, 32'h0, 1'b1, 0, "err_sw22");
        op(0, WR, LR, 32'h20, 32'h6666_6666, 32'h0, 1'b1, 0, "err_len3w");
        op(0, RD, LR, 32'h20, 32'h0, 32'h0, 1'b1, 0, "err_len3r");
        op(0, RD, LW, 32'h1000, 32'h0, 32'h0, 1'b1, 0, "err_oor");
        op(0, RD, LW, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 0, "err_wrap");
        op(0, RD, LW, 32'h0FFC, 32'h0, 32'h0, 1'b0, 0, "last_word");
        op(0, RD, LW, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 0, "lw20");

        // LATENCY=4: stall 3 cycles, then back-to-back accept on the release cycle
        op(1, WR, LW, 32'h40, 32'h1111_1111, 32'h0, 1'b0, 0, "l4_sw40");
        @(negedge clk);
        ctrl_d[1] = {1'b1, RD, LW}; addr_d[1] = 32'h40; rdy_d[1] = 1'b0;
        @(posedge clk);
        #1;
        ctrl_d[1] = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_o[1] && n < 20);
        check_eq("l4_stall/lat", 32'(n), 32'd4);
        check_eq("l4_stall/rdata", rd_o[1], 32'h1111_1111);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!vld_o[1] || rd_o[1] !== 32'h1111_1111 || err_o[1] || mt_o[1] || rrdy_o[1]) stable = 1'b0;
            @(negedge clk);
        end
        check_eq("l4_stall/hold", 32'(stable), 32'd1);
        rdy_d[1] = 1'b1;
        ctrl_d[1] = {1'b1, WR, LW}; addr_d[1] = 32'h44; wd_d[1] = 32'h2222_2222;
        #1;
        check_eq("l4_b2b/req_rdy", 32'(rrdy_o[1]), 32'd1);
        check_eq("l4_b2b/vld_held", 32'(vld_o[1]), 32'd1);
        @(posedge clk);
        #1;
        ctrl_d[1] = '0;
        check_eq("l4_b2b/vld_drop", 32'(vld_o[1]), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_o[1] && n < 20);
        check_eq("l4_b2b/lat", 32'(n), 32'd4);
        check_eq("l4_b2b/err", 32'(err_o[1]), 32'd0);
        check_eq("l4_b2b/mtype", 32'(mt_o[1]), 32'd1);
        op(1, RD, LW, 32'h44, 32'h0, 32'h2222_2222, 1'b0, 0, "l4_lw44");
        op(1, WR, LW, 32'h44, 32'h3333_3333, 32'h0, 1'b0, 0, "l4_sw44");

        // Reset during WAIT of a write must discard it
        @(negedge clk);
        ctrl_d[1] = {1'b1, WR, LW}; addr_d[1] = 32'h40; wd_d[1] = 32'h9999_9999;
        @(posedge clk);
        #1;
        ctrl_d[1] = '0;
        @(negedge clk);
        rst_d[1] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("l4_rst/vld", 32'(vld_o[1]), 32'd0);
        check_eq("l4_rst/req_rdy", 32'(rrdy_o[1]), 32'd1);
        check_eq("l4_rst/mtype", 32'(mt_o[1]), 32'd0);
        check_eq("l4_rst/err", 32'(err_o[1]), 32'd0);
        @(negedge clk);
        rst_d[1] = 1'b1;
        op(1, RD, LW, 32'h40, 32'h0, 32'h1111_1111, 1'b0, 0, "l4_rst_lw40");

        // Random traffic on the LATENCY=1 unit against a byte-level model
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            op(0, WR, LW, 32'(w * 4), wd, 32'h0, 1'b0, 0, "fill");
            for (int b = 0; b < 4; b++) ref_b[w*4 + b] = wd[8*b +: 8];
        end
        for (int i = 0; i < 400; i++) begin
            mt  = 1'($urandom_range(0, 1));
            len = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, 255));
            ia = a[7:0];
            e = (len == LR) || (len == LH && a[0]) || (len == LW && a[1:0] != 2'd0) || (a >= 32'h1000);
            exp = '0;
            if (!e && mt == RD) begin
                case (len)
                    LB: exp = {24'b0, ref_b[ia]};
                    LH: exp = {16'b0, ref_b[ia + 8'd1], ref_b[ia]};
                    default: exp = {ref_b[ia + 8'd3], ref_b[ia + 8'd2], ref_b[ia + 8'd1], ref_b[ia]};
                endcase
            end
            op(0, mt, len, a, wd, exp, e, $urandom_range(0, 2), "rnd");
            if (!e && mt == WR) begin
                ref_b[ia] = wd[7:0];
                if (len != LB) ref_b[ia + 8'd1] = wd[15:8];
                if (len == LW) begin
                    ref_b[ia + 8'd2] = wd[23:16];
                    ref_b[ia + 8'd3] = wd[31:24];
                end
            end
        end

        @(negedge clk);
        check_eq("final/idle1", 32'(vld_o[0]), 32'd0);
        check_eq("final/idle4", 32'(vld_o[1]), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
